// File: rtl/sodor5_stim_pkg.sv
// Shared types, opcode constants and LFSR/decode helpers for the sodor5
// instruction-stimulus sequencer.
package sodor5_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } stim_state_e;

  localparam logic [6:0]  OP_IMM        = 7'b0010011;
  localparam logic [6:0]  OP_LOAD       = 7'b0000011;
  localparam logic [31:0] NOP           = 32'h00000013;
  // SRLI/SRAI keep shamt plus the arithmetic-select bit; SLLI keeps shamt only
  localparam logic [11:0] SHIFT_MASK_SR = 12'h41F;
  localparam logic [11:0] SHIFT_MASK_SL = 12'h01F;
  localparam logic [31:0] LFSR_TAPS     = 32'h80200003;

  // One right-shifting Galois step
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Map an LFSR state onto either a legal I-type ALU op or an LB/LBU
  function automatic logic [31:0] stim_decode(input logic [31:0] s);
    logic [11:0] imm;
    logic [2:0]  f3;
    logic [31:0] word;
    imm = s[31:20];
    f3  = s[14:12];
    if (s[0]) begin
      if (f3 == 3'd5)      imm = imm & SHIFT_MASK_SR;
      else if (f3 == 3'd1) imm = imm & SHIFT_MASK_SL;
      word = {imm, s[19:15], f3, s[11:7], OP_IMM};
    end else begin
      word = {imm, s[19:15], f3 & 3'b100, s[11:7], OP_LOAD};
    end
    return word;
  endfunction

endpackage

// File: rtl/imem_stim_sequencer_lfsr32.sv
// 32-bit Galois LFSR with seed load on reset and an advance enable.
module stim_lfsr32
  import sodor5_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000027B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  output logic [31:0] state_o
);

  // An all-zero state would lock up the LFSR
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] state_q, state_d;

  // Step only when the consumer has taken a generated word
  always_comb begin
    state_d = adv ? lfsr_step(state_q) : state_q;
  end

  // State register, reloaded with the seed on reset only
  always_ff @(posedge clk) begin
    if (reset) state_q <= SEED_EFF;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/imem_stim_sequencer.sv
// Phased instruction-stimulus sequencer: warm-up NOPs, LFSR-generated
// ALU/load stream with load-use hazard guard, drain NOPs, ready handshake.
module imem_stim_sequencer
  import sodor5_stim_pkg::*;
#(
  parameter logic [31:0] SEED         = 32'h0000027B,
  parameter int unsigned NUM_INSTRS   = 100,
  parameter int unsigned WARMUP_NOPS  = 3,
  parameter int unsigned DRAIN_NOPS   = 5,
  parameter int unsigned LOAD_USE_GAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        is_load,
  output logic        busy,
  output logic        done,
  output logic [31:0] issued_count
);

  // Empty phases collapse into the following one
  localparam stim_state_e AFTER_RUN  = (DRAIN_NOPS  > 0) ? ST_DRAIN  : ST_DONE;
  localparam stim_state_e AFTER_WARM = (NUM_INSTRS  > 0) ? ST_RUN    : AFTER_RUN;
  localparam stim_state_e FIRST      = (WARMUP_NOPS > 0) ? ST_WARMUP : AFTER_WARM;

  stim_state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] issued_q, issued_d;
  logic [31:0] gap_q, gap_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        is_load_q, is_load_d;
  logic        gen_q, gen_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic        lfsr_adv;
  logic [31:0] lfsr_q;
  logic [31:0] lfsr_nxt;
  logic        hazard;

  stim_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .adv     (lfsr_adv),
    .state_o (lfsr_q)
  );

  // Phase FSM, counters, hazard tracker and look-ahead of the next word
  always_comb begin
    accept   = valid_q & ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    gap_d    = gap_q;
    ld_rd_d  = ld_rd_q;
    lfsr_adv = 1'b0;

    if (accept) begin
      if (gen_q && is_load_q && (instr_q[11:7] != 5'd0)) begin
        ld_rd_d = instr_q[11:7];
        gap_d   = 32'd0;
      end else if (gap_q < 32'(LOAD_USE_GAP)) begin
        gap_d = gap_q + 32'd1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = FIRST;
          cnt_d    = 32'd0;
          issued_d = 32'd0;
        end
      end
      ST_WARMUP: begin
        if (accept) begin
          if (cnt_q + 32'd1 == 32'(WARMUP_NOPS)) begin
            state_d = AFTER_WARM;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      ST_RUN: begin
        // Hazard NOPs are accepted without touching LFSR or run count
        if (accept && gen_q) begin
          lfsr_adv = 1'b1;
          issued_d = issued_q + 32'd1;
          if (cnt_q + 32'd1 == 32'(NUM_INSTRS)) begin
            state_d = AFTER_RUN;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          if (cnt_q + 32'd1 == 32'(DRAIN_NOPS)) begin
            state_d = ST_DONE;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Candidate is decoded from the LFSR value that will hold next cycle
    lfsr_nxt  = lfsr_adv ? lfsr_step(lfsr_q) : lfsr_q;
    hazard    = (ld_rd_d != 5'd0) && (lfsr_nxt[19:15] == ld_rd_d) &&
                (gap_d < 32'(LOAD_USE_GAP));
    gen_d     = (state_d == ST_RUN) && !hazard;
    instr_d   = gen_d ? stim_decode(lfsr_nxt) : NOP;
    is_load_d = gen_d && !lfsr_nxt[0];
    valid_d   = (state_d == ST_WARMUP) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    busy_d    = valid_d;
    done_d    = (state_d == ST_DONE);
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 32'd0;
      issued_q  <= 32'd0;
      gap_q     <= 32'd0;
      ld_rd_q   <= 5'd0;
      instr_q   <= NOP;
      valid_q   <= 1'b0;
      is_load_q <= 1'b0;
      gen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      issued_q  <= issued_d;
      gap_q     <= gap_d;
      ld_rd_q   <= ld_rd_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      is_load_q <= is_load_d;
      gen_q     <= gen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign instr        = instr_q;
  assign instr_valid  = valid_q;
  assign is_load      = is_load_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign issued_count = issued_q;

endmodule

// File: tb/tb_imem_stim_sequencer.sv
// Scoreboard bench for imem_stim_sequencer: a transaction-level stream model
// queues expected words, a negedge monitor pops and compares accepted words.
module tb_imem_stim_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ready;
  logic [31:0] instr;
  logic        instr_valid, is_load, busy, done;
  logic [31:0] issued_count;

  logic        start_b;
  logic        ready_b;
  logic [31:0] instr_b;
  logic        instr_valid_b, is_load_b, busy_b, done_b;
  logic [31:0] issued_count_b;

  always #5 clk = ~clk;

  imem_stim_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .instr(instr), .instr_valid(instr_valid), .is_load(is_load),
    .busy(busy), .done(done), .issued_count(issued_count)
  );

  // Seed chosen so that "lb x5,0(x10)" is directly followed by "lb x2,0(x5)"
  imem_stim_sequencer #(
    .SEED(32'h00050280), .NUM_INSTRS(2), .WARMUP_NOPS(1), .DRAIN_NOPS(1), .LOAD_USE_GAP(1)
  ) dut_haz (
    .clk(clk), .reset(reset), .start(start_b), .ready(ready_b),
    .instr(instr_b), .instr_valid(instr_valid_b), .is_load(is_load_b),
    .busy(busy_b), .done(done_b), .issued_count(issued_count_b)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] w;
    logic        ld;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] acc_q[$];
  int          total_words = 0;
  bit          rand_ready = 1'b0;

  logic [31:0] m_lfsr;
  logic [4:0]  m_rd;
  int          m_gap;
  int          m_slots;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] s);
    logic [11:0] imm;
    logic [2:0]  f3;
    imm = s[31:20];
    f3  = s[14:12];
    if (!s[0]) return {imm, s[19:15], {f3[2], 2'b00}, s[11:7], 7'h03};
    if (f3 == 3'd5) imm = imm & 12'h41F;
    if (f3 == 3'd1) imm = imm & 12'h01F;
    return {imm, s[19:15], f3, s[11:7], 7'h13};
  endfunction

  function automatic logic legal(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    if (w[6:0] == 7'h13) begin
      if (f3 == 3'd1) return (w[31:25] == 7'd0);
      if (f3 == 3'd5) return (w[31] == 1'b0) && (w[29:25] == 5'd0);
      return 1'b1;
    end
    if (w[6:0] == 7'h03) return (f3 == 3'd0) || (f3 == 3'd4);
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_lfsr = 32'h0000027B;
    m_rd   = 5'd0;
    m_gap  = 0;
  endtask

  task automatic model_slot(input logic [31:0] w, input logic ld, input bit gen);
    exp_q.push_back({w, ld});
    m_slots++;
    if (gen && ld && (w[11:7] != 5'd0)) begin
      m_rd  = w[11:7];
      m_gap = 0;
    end else if (m_gap < 1) begin
      m_gap++;
    end
  endtask

  // Expected accepted stream of one whole run with default parameters
  task automatic model_run();
    int gen;
    m_slots = 0;
    repeat (3) model_slot(32'h13, 1'b0, 1'b0);
    gen = 0;
    while (gen < 100) begin
      if ((m_rd != 5'd0) && (m_lfsr[19:15] == m_rd) && (m_gap < 1)) begin
        model_slot(32'h13, 1'b0, 1'b0);
      end else begin
        model_slot(m_word(m_lfsr), ~m_lfsr[0], 1'b1);
        m_lfsr = m_step(m_lfsr);
        gen++;
      end
    end
    repeat (5) model_slot(32'h13, 1'b0, 1'b0);
  endtask

  // Monitor: scoreboard pop on each accepted slot, plus stall-hold check
  bit          stall_prev = 1'b0;
  logic [31:0] stall_w;
  logic        stall_ld;
  exp_t        e;
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && instr_valid) begin
        chk("stall_hold_instr", instr, stall_w);
        chk("stall_hold_is_load", {31'd0, is_load}, {31'd0, stall_ld});
      end
      if (instr_valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h expected=none at %0t", instr, $time);
        end else begin
          e = exp_q.pop_front();
          chk("stream_word", instr, e.w);
          chk("stream_is_load", {31'd0, is_load}, {31'd0, e.ld});
        end
        chk("word_legal", {31'd0, legal(instr)}, 32'd1);
        acc_q.push_back(instr);
        total_words++;
      end
      stall_prev = instr_valid && !ready;
      stall_w    = instr;
      stall_ld   = is_load;
    end
  end

  // Ready driver: changes just after the rising edge
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int vcyc);
    int n;
    n = 0;
    vcyc = 0;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      if (instr_valid) vcyc++;
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done expected=done within %0d cycles", budget);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1);
  end

  logic [31:0] hz_w[5];
  logic        hz_l[5];
  logic [31:0] exp_hz_w[5];
  logic        exp_hz_l[5];

  initial begin
    int v;
    int nh;
    reset   = 1'b1;
    start   = 1'b0;
    start_b = 1'b0;
    ready_b = 1'b1;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr", instr, 32'h13);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_is_load", {31'd0, is_load}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_issued", issued_count, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Run 1: ready high, first words hand-decoded from SEED
    model_run();
    acc_q.delete();
    pulse_start();
    run_until_done(3000, v);
    chk("run1_done_latency", v, m_slots);
    chk("run1_issued", issued_count, 32'd100);
    chk("run1_done", {31'd0, done}, 32'd1);
    chk("run1_idle_valid", {31'd0, instr_valid}, 32'd0);
    chk("run1_idle_busy", {31'd0, busy}, 32'd0);
    chk("run1_warm0", acc_q[0], 32'h13);
    chk("run1_warm2", acc_q[2], 32'h13);
    chk("run1_word0", acc_q[3], 32'h00000213);
    chk("run1_word1", acc_q[4], 32'h80200103);
    chk("run1_word2", acc_q[5], 32'h40100093);
    chk("run1_word3", acc_q[6], 32'hA0280003);
    chk("run1_queue_empty", exp_q.size(), 32'd0);

    // Run 2: random stalls, LFSR continues from run 1
    rand_ready = 1'b1;
    model_run();
    pulse_start();
    run_until_done(6000, v);
    rand_ready = 1'b0;
    chk("run2_issued", issued_count, 32'd100);
    chk("run2_queue_empty", exp_q.size(), 32'd0);

    // Reset mid-RUN, then a fresh start reproduces the seed stream
    model_run();
    pulse_start();
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_instr", instr, 32'h13);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_issued", issued_count, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    model_reset();
    model_run();
    acc_q.delete();
    pulse_start();
    run_until_done(3000, v);
    chk("rerun_word0", acc_q[3], 32'h00000213);
    chk("rerun_word1", acc_q[4], 32'h80200103);
    chk("rerun_issued", issued_count, 32'd100);
    chk("rerun_queue_empty", exp_q.size(), 32'd0);

    // start held high: no restart while busy, immediate restart from DONE
    model_run();
    model_run();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    run_until_done(3000, v);
    @(negedge clk);
    chk("held_restart_valid", {31'd0, instr_valid}, 32'd1);
    chk("held_restart_done", {31'd0, done}, 32'd0);
    chk("held_restart_issued", issued_count, 32'd0);
    repeat (40) @(posedge clk);
    #1 start = 1'b0;
    run_until_done(3000, v);
    chk("held_issued", issued_count, 32'd100);
    chk("held_queue_empty", exp_q.size(), 32'd0);

    // Bulk legality over more than 10^4 words
    for (int r = 0; r < 92; r++) begin
      model_run();
      pulse_start();
      run_until_done(3000, v);
    end
    chk("bulk_queue_empty", exp_q.size(), 32'd0);
    chk("bulk_words_ge_10k", {31'd0, (total_words >= 10000)}, 32'd1);

    // Hazard instance: lb x5 / NOP / lb x2,0(x5)
    exp_hz_w[0] = 32'h00000013; exp_hz_l[0] = 1'b0;
    exp_hz_w[1] = 32'h00050283; exp_hz_l[1] = 1'b1;
    exp_hz_w[2] = 32'h00000013; exp_hz_l[2] = 1'b0;
    exp_hz_w[3] = 32'h00028103; exp_hz_l[3] = 1'b1;
    exp_hz_w[4] = 32'h00000013; exp_hz_l[4] = 1'b0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    nh = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_b) break;
      if (instr_valid_b && nh < 5) begin
        hz_w[nh] = instr_b;
        hz_l[nh] = is_load_b;
      end
      if (instr_valid_b) nh++;
    end
    chk("haz_slots", nh, 32'd5);
    chk("haz_done", {31'd0, done_b}, 32'd1);
    chk("haz_issued", issued_count_b, 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i < nh) begin
        chk($sformatf("haz_word%0d", i), hz_w[i], exp_hz_w[i]);
        chk($sformatf("haz_is_load%0d", i), {31'd0, hz_l[i]}, {31'd0, exp_hz_l[i]});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
